time_preset_loader: RTL and testbench

TIME_PRESET_LOADER -- requirements
Module: time_preset_loader

---
 rtl/time_preset_pkg.sv | 41 ++++
 rtl/btn_debounce.sv | 48 ++++
 rtl/time_preset_loader.sv | 157 +++++++++++++++
 tb/tb_time_preset_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_preset_pkg.sv
// Shared types and constants for the time preset loader: FSM states,
// edit-field encodings, BCD field limits, reset preset and BCD increment helper.
package time_preset_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_EDIT_HR  = 3'd1,
    ST_EDIT_MIN = 3'd2,
    ST_EDIT_SEC = 3'd3,
    ST_COMMIT   = 3'd4
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HR   = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_SEC  = 2'b11;

  // Two-digit BCD upper limits of each field
  localparam logic [7:0] HR_MAX_BCD = 8'h11;
  localparam logic [7:0] MS_MAX_BCD = 8'h59;

  // Preset loaded on reset: 11:59:59
  localparam logic [7:0] PRESET_HR  = 8'h11;
  localparam logic [7:0] PRESET_MIN = 8'h59;
  localparam logic [7:0] PRESET_SEC = 8'h59;

  // Increment a two-digit BCD value, wrapping to 00 after lim; no carry out
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] lim);
    logic [7:0] res;
    res = 8'h00;
    if (val == lim) begin
      res = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, stable-count debouncer and
// a one-clock press pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;

  // Synchronize, then accept a new level only after DB_CYCLES consecutive differing clocks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn};
      r_press <= 1'b0;
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
          r_press <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/time_preset_loader.sv
// Two-button preset editor for a countdown: mode steps hours/minutes/seconds
// editing and commits with a one-clock load strobe; inc bumps the selected
// BCD field. Optional build macro AUTO_REPEAT_EN adds held-button auto-repeat.
module time_preset_loader
  import time_preset_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 20000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] set_hr1,
  output logic [3:0] set_hr0,
  output logic [3:0] set_min1,
  output logic [3:0] set_min0,
  output logic [3:0] set_sec1,
  output logic [3:0] set_sec0,
  output logic       load,
  output logic       edit_active,
  output logic [1:0] edit_field
);

  state_e     r_state;
  logic [7:0] r_hr;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic       r_load;
  logic       r_edit_active;
  logic [1:0] r_edit_field;

  logic w_mode_level;
  logic w_mode_press;
  logic w_inc_level;
  logic w_inc_press;
  logic w_in_edit;
  logic w_rep;
  logic w_inc_evt;
  logic w_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_mode),
    .level (w_mode_level),
    .press (w_mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_inc),
    .level (w_inc_level),
    .press (w_inc_press)
  );

  assign w_in_edit = (r_state == ST_EDIT_HR) || (r_state == ST_EDIT_MIN) ||
                     (r_state == ST_EDIT_SEC);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep_cnt;

  assign w_rep    = w_in_edit && w_inc_level && !w_inc_press && (r_rep_cnt == REP_LAST);
  assign w_unused = &{1'b0, w_mode_level};

  // Hold timer: restarts on every press or when the hold/edit condition drops
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep_cnt <= '0;
    end else if (!w_in_edit || !w_inc_level || w_inc_press || w_mode_press) begin
      r_rep_cnt <= '0;
    end else if (r_rep_cnt == REP_LAST) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + REP_W'(1);
    end
  end
`else
  assign w_rep    = 1'b0;
  assign w_unused = &{1'b0, w_mode_level, w_inc_level, 32'(REPEAT_CYCLES)};
`endif

  assign w_inc_evt = w_inc_press | w_rep;

  // Edit FSM with registered outputs; mode press outranks inc in the same clock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_hr          <= PRESET_HR;
      r_min         <= PRESET_MIN;
      r_sec         <= PRESET_SEC;
      r_load        <= 1'b0;
      r_edit_active <= 1'b0;
      r_edit_field  <= FIELD_NONE;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_mode_press) begin
            r_state       <= ST_EDIT_HR;
            r_edit_active <= 1'b1;
            r_edit_field  <= FIELD_HR;
          end
        end
        ST_EDIT_HR: begin
          if (w_mode_press) begin
            r_state      <= ST_EDIT_MIN;
            r_edit_field <= FIELD_MIN;
          end else if (w_inc_evt) begin
            r_hr <= bcd_inc(r_hr, HR_MAX_BCD);
          end
        end
        ST_EDIT_MIN: begin
          if (w_mode_press) begin
            r_state      <= ST_EDIT_SEC;
            r_edit_field <= FIELD_SEC;
          end else if (w_inc_evt) begin
            r_min <= bcd_inc(r_min, MS_MAX_BCD);
          end
        end
        ST_EDIT_SEC: begin
          if (w_mode_press) begin
            r_state       <= ST_COMMIT;
            r_load        <= 1'b1;
            r_edit_active <= 1'b0;
            r_edit_field  <= FIELD_NONE;
          end else if (w_inc_evt) begin
            r_sec <= bcd_inc(r_sec, MS_MAX_BCD);
          end
        end
        ST_COMMIT: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state       <= ST_RUN;
          r_edit_active <= 1'b0;
          r_edit_field  <= FIELD_NONE;
        end
      endcase
    end
  end

  assign set_hr1     = r_hr[7:4];
  assign set_hr0     = r_hr[3:0];
  assign set_min1    = r_min[7:4];
  assign set_min0    = r_min[3:0];
  assign set_sec1    = r_sec[7:4];
  assign set_sec0    = r_sec[3:0];
  assign load        = r_load;
  assign edit_active = r_edit_active;
  assign edit_field  = r_edit_field;

endmodule

// File: tb/tb_time_preset_loader.sv
// Randomized self-checking bench for time_preset_loader against an integer
// hours/minutes/seconds reference model.
module tb_time_preset_loader;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0;
  logic       load;
  logic       edit_active;
  logic [1:0] edit_field;

  time_preset_loader #(.DB_CYCLES(DB), .REPEAT_CYCLES(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .set_hr1     (set_hr1),
    .set_hr0     (set_hr0),
    .set_min1    (set_min1),
    .set_min0    (set_min0),
    .set_sec1    (set_sec1),
    .set_sec0    (set_sec0),
    .load        (load),
    .edit_active (edit_active),
    .edit_field  (edit_field)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: field 0 = run, 1 = hours, 2 = minutes, 3 = seconds
  int          m_field;
  int          m_hr, m_min, m_sec;
  int          m_loads;
  logic [23:0] m_load_val;

  // Observed load strobes and inc press pulses
  int          c_loads     = 0;
  logic [23:0] c_load_val  = '0;
  int          inc_pulses  = 0;

  function automatic logic [23:0] bcd6(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load === 1'b1) begin
      c_loads    <= c_loads + 1;
      c_load_val <= {set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0};
    end
    if (dut.u_db_inc.press === 1'b1) inc_pulses <= inc_pulses + 1;
  end

  task automatic model_reset();
    m_field = 0;
    m_hr    = 11;
    m_min   = 59;
    m_sec   = 59;
  endtask

  task automatic model_mode();
    if (m_field == 3) begin
      m_loads++;
      m_load_val = bcd6(m_hr, m_min, m_sec);
      m_field    = 0;
    end else begin
      m_field++;
    end
  endtask

  task automatic model_inc();
    case (m_field)
      1: m_hr  = (m_hr + 1) % 12;
      2: m_min = (m_min + 1) % 60;
      3: m_sec = (m_sec + 1) % 60;
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, "_field"},  32'(edit_field), 32'(m_field));
    check({tag, "_active"}, 32'(edit_active), 32'(m_field != 0));
    check({tag, "_digits"}, 32'({set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0}),
          32'(bcd6(m_hr, m_min, m_sec)));
    check({tag, "_loads"},  32'(c_loads), 32'(m_loads));
    if (m_loads > 0) check({tag, "_loadval"}, 32'(c_load_val), 32'(m_load_val));
  endtask

  // Clean press of mode and/or inc; checks the one-clock press-to-state latency
  task automatic do_press(input bit m, input bit i, input string tag);
    int  exp_f;
    bit  exp_load;
    bit  seen;
    exp_load = 1'b0;
    exp_f    = m_field;
    if (m) begin
      if (m_field == 3) begin
        exp_f    = 0;
        exp_load = 1'b1;
      end else begin
        exp_f = m_field + 1;
      end
    end
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    seen     = 1'b0;
    for (int k = 0; k < int'(DB) + 10 && !seen; k++) begin
      @(negedge clk);
      if ((m && dut.u_db_mode.press === 1'b1) || (!m && dut.u_db_inc.press === 1'b1)) seen = 1'b1;
    end
    check({tag, "_press_seen"}, 32'(seen), 32'd1);
    if (seen && m) begin
      @(negedge clk);
      check({tag, "_latency_field"}, 32'(edit_field), 32'(exp_f));
      check({tag, "_load_strobe"},   32'(load), 32'(exp_load));
    end
    repeat ($urandom_range(0, 4)) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (DB + 6) @(negedge clk);
    if (m) model_mode();
    else if (i) model_inc();
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check({tag, "_rst_field"},  32'(edit_field), 32'd0);
    check({tag, "_rst_active"}, 32'(edit_active), 32'd0);
    check({tag, "_rst_load"},   32'(load), 32'd0);
    check({tag, "_rst_digits"}, 32'({set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0}),
          32'h115959);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int start_pulses;
    int r;

    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    m_loads  = 0;
    m_load_val = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_load", 32'(load), 32'd0);
    check_all("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Enter hours edit, then hours 11 -> 00
    do_press(1'b1, 1'b0, "mode_to_hr");
    do_press(1'b0, 1'b1, "hr_wrap");

    // Simultaneous mode and inc: mode wins, hours untouched
    do_press(1'b1, 1'b1, "both_hr");

    // Minutes 59 -> 00, then 00..09, then 09 -> 10
    do_press(1'b0, 1'b1, "min_wrap");
    for (int k = 0; k < 9; k++) do_press(1'b0, 1'b1, "min_step");
    do_press(1'b0, 1'b1, "min_carry");

    // Seconds edit then commit
    do_press(1'b1, 1'b0, "mode_to_sec");
    do_press(1'b0, 1'b1, "sec_inc");
    do_press(1'b1, 1'b0, "commit");

    // Inc in RUN is ignored
    do_press(1'b0, 1'b1, "run_inc");

    // Bouncing inc in hours edit yields exactly one press after stable hold
    do_press(1'b1, 1'b0, "bounce_enter");
    start_pulses = inc_pulses;
    @(negedge clk); btn_inc = 1'b1;
    @(negedge clk); btn_inc = 1'b0;
    @(negedge clk); btn_inc = 1'b1;
    @(negedge clk); btn_inc = 1'b0;
    @(negedge clk); btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    check("bounce_early", 32'(inc_pulses - start_pulses), 32'd0);
    repeat (DB + 6) @(negedge clk);
    btn_inc = 1'b0;
    repeat (DB + 6) @(negedge clk);
    check("bounce_pulses", 32'(inc_pulses - start_pulses), 32'd1);
    model_inc();
    check_all("bounce");

    // Randomized mix of actions
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0)      do_reset("rnd_reset");
      else if (r < 4)  do_press(1'b1, 1'b0, "rnd_mode");
      else if (r < 9)  do_press(1'b0, 1'b1, "rnd_inc");
      else             do_press(1'b1, 1'b1, "rnd_both");
    end

    // Reset in seconds edit abandons the edit without a load
    for (int k = 0; k < 5 && m_field != 3; k++) do_press(1'b1, 1'b0, "to_sec");
    do_press(1'b0, 1'b1, "pre_reset_inc");
    do_reset("sec_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
